// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit-counter width; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for serial_subtractor.
// Optional outOvf signal exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(
  parameter int WIDTH = serial_sub_pkg::DEFAULT_WIDTH
);
  logic             inStart;
  logic [WIDTH-1:0] inOp1;
  logic [WIDTH-1:0] inOp2;
  logic             inBi;
  logic             outBusy;
  logic             outDone;
  logic [WIDTH-1:0] outRes;
  logic             outBo;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             outOvf;

  modport master (
    output inStart, inOp1, inOp2, inBi,
    input  outBusy, outDone, outRes, outBo, outOvf
  );

  modport slave (
    input  inStart, inOp1, inOp2, inBi,
    output outBusy, outDone, outRes, outBo, outOvf
  );
`else
  modport master (
    output inStart, inOp1, inOp2, inBi,
    input  outBusy, outDone, outRes, outBo
  );

  modport slave (
    input  inStart, inOp1, inOp2, inBi,
    output outBusy, outDone, outRes, outBo
  );
`endif
endinterface

// File: rtl/serial_subtractor_fullSubtractor.sv
// Single-bit full subtractor: d = a - b - bi, with borrow-out bo.
module fullSubtractor (
  input  logic a_i,
  input  logic b_i,
  input  logic bi_i,
  output logic d_o,
  output logic bo_o
);

  assign d_o  = a_i ^ b_i ^ bi_i;
  assign bo_o = (~a_i & b_i) | (~(a_i ^ b_i) & bi_i);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (LSB first) with start/done handshake.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed-overflow output outOvf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             bor_q, bor_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bo_q, bo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             am_q, am_d;
  logic             bm_q, bm_d;
  logic             ovf_q, ovf_d;
`endif

  logic fs_d;
  logic fs_bo;

  // The one cell is reused every cycle on the current LSBs and the borrow FF.
  fullSubtractor u_fs (
    .a_i  (a_q[0]),
    .b_i  (b_q[0]),
    .bi_i (bor_q),
    .d_o  (fs_d),
    .bo_o (fs_bo)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    bor_d   = bor_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    bo_d    = bo_q;
    done_d  = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
    am_d    = am_q;
    bm_d    = bm_q;
    ovf_d   = ovf_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.inStart) begin
          a_d     = bus.inOp1;
          b_d     = bus.inOp2;
          bor_d   = bus.inBi;
          r_d     = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
`ifdef SERIAL_SUB_OVERFLOW_EN
          am_d    = bus.inOp1[WIDTH-1];
          bm_d    = bus.inOp2[WIDTH-1];
`endif
        end
      end

      ST_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = {fs_d, r_q[WIDTH-1:1]};
        bor_d = fs_bo;
        cnt_d = cnt_q + CNT_ONE;
        // Last bit: publish the fully shifted result together with the final borrow.
        if (cnt_q == CNT_LAST) begin
          res_d   = {fs_d, r_q[WIDTH-1:1]};
          bo_d    = fs_bo;
          done_d  = 1'b1;
          state_d = ST_DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
          ovf_d   = (am_q != bm_q) && (fs_d != am_q);
`endif
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      bor_q   <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      bo_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      bor_q   <= bor_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      bo_q    <= bo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      am_q    <= am_d;
      bm_q    <= bm_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.outBusy = busy_q;
  assign bus.outDone = done_q;
  assign bus.outRes  = res_q;
  assign bus.outBo   = bo_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign bus.outOvf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor with a transaction-level reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain arithmetic difference, result visible W cycles after start.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bi);
    logic [W:0] diff;
    logic       ovf;
    diff = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    ovf  = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
    return {ovf, diff[W], diff[W-1:0]};
  endfunction

  int             m_phase = 0;
  int             m_left  = 0;
  logic           m_busy  = 1'b0;
  logic           m_done  = 1'b0;
  logic [W-1:0]   m_res   = '0;
  logic           m_bo    = 1'b0;
  logic           m_ovf   = 1'b0;
  logic [W+1:0]   m_pend  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_res   <= '0;
      m_bo    <= 1'b0;
      m_ovf   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_phase == 0) begin
        if (bus.inStart) begin
          m_pend  <= ref_sub(bus.inOp1, bus.inOp2, bus.inBi);
          m_left  <= W;
          m_phase <= 1;
          m_busy  <= 1'b1;
        end
      end else if (m_phase == 1) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          {m_ovf, m_bo, m_res} <= m_pend;
          m_done  <= 1'b1;
          m_phase <= 2;
        end
      end else begin
        m_phase <= 0;
        m_busy  <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_busy", bus.outBusy, m_busy);
    chk("cyc_done", bus.outDone, m_done);
    chk("cyc_res",  bus.outRes,  m_res);
    chk("cyc_bo",   bus.outBo,   m_bo);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("cyc_ovf",  bus.outOvf,  m_ovf);
`endif
  end

  task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic bi, input logic [W-1:0] er, input logic eb);
    int dn;
    int busyc;
    dn    = 0;
    busyc = 0;
    @(negedge clk);
    bus.inStart = 1'b1;
    bus.inOp1   = a;
    bus.inOp2   = b;
    bus.inBi    = bi;
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.inStart = 1'b0;
        bus.inOp1   = a ^ 8'hA5;
        bus.inOp2   = b ^ 8'h3C;
        bus.inBi    = ~bi;
      end
      if (bus.outBusy) busyc++;
      if (bus.outDone && dn == 0) dn = k;
    end
    chk({nm, "_lat"},  dn, W + 1);
    chk({nm, "_busy"}, busyc, W + 1);
    chk({nm, "_res"},  bus.outRes, er);
    chk({nm, "_bo"},   bus.outBo, eb);
    chk({nm, "_mres"}, m_res, er);
  endtask

  initial begin
    bus.inStart = 1'b0;
    bus.inOp1   = '0;
    bus.inOp2   = '0;
    bus.inBi    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.outBusy, 0);
    chk("rst_done", bus.outDone, 0);
    chk("rst_res",  bus.outRes, 0);
    chk("rst_bo",   bus.outBo, 0);
    rst_n = 1'b1;

    do_op("basic", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0);

    // Abort mid-run: previous result visible until reset clears everything.
    @(negedge clk);
    bus.inStart = 1'b1;
    bus.inOp1   = 8'h77;
    bus.inOp2   = 8'h22;
    bus.inBi    = 1'b0;
    @(negedge clk);
    bus.inStart = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_busy_pre", bus.outBusy, 1);
    chk("abort_res_held", bus.outRes, 8'h23);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.outBusy, 0);
    chk("abort_res",  bus.outRes, 0);
    chk("abort_done", bus.outDone, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    do_op("after_rst", 8'h09, 8'h03, 1'b0, 8'h06, 1'b0);
    do_op("wrap",      8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    do_op("bin",       8'h10, 8'h0F, 1'b1, 8'h00, 1'b0);
    do_op("ovf1",      8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("ovf1_ovf", bus.outOvf, 1);
`endif
    do_op("ovf0",      8'h05, 8'h03, 1'b0, 8'h02, 1'b0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("ovf0_ovf", bus.outOvf, 0);
`endif

    // inStart held high through RUN/DONE: one completion, then a fresh accept.
    begin
      int dn;
      int ndone;
      int idle_k;
      int rebusy_k;
      dn = 0; ndone = 0; idle_k = 0; rebusy_k = 0;
      @(negedge clk);
      bus.inStart = 1'b1;
      bus.inOp1   = 8'h55;
      bus.inOp2   = 8'h11;
      bus.inBi    = 1'b0;
      for (int k = 1; k <= W + 4; k++) begin
        @(negedge clk);
        if (k == 1) begin
          bus.inOp1 = 8'hFF;
          bus.inOp2 = 8'hFF;
        end
        if (bus.outDone) begin
          ndone++;
          if (dn == 0) begin
            dn = k;
            chk("hold_res", bus.outRes, 8'h44);
          end
        end
        if (dn != 0 && idle_k == 0 && !bus.outBusy) idle_k = k;
        if (idle_k != 0 && rebusy_k == 0 && bus.outBusy) rebusy_k = k;
      end
      chk("hold_lat",    dn, W + 1);
      chk("hold_ndone",  ndone, 1);
      chk("hold_idle",   idle_k, W + 2);
      chk("hold_rebusy", rebusy_k, W + 3);
      bus.inStart = 1'b0;
      dn = 0;
      for (int k = 1; k <= 2 * W; k++) begin
        @(negedge clk);
        if (bus.outDone && dn == 0) dn = k;
      end
      chk("hold2_seen", (dn != 0), 1);
      chk("hold2_res",  bus.outRes, 8'h00);
      chk("hold2_bo",   bus.outBo, 0);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor; computes inOp1 - inOp2 - inBi one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Sequential, inverse-operation companion to the team's combinational adder chain.
- Area-cheap subtraction for datapaths that can tolerate WIDTH-cycle latency; start/done handshake toward the controlling FSM.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- inStart  input  1  request; sampled only in IDLE.
- inOp1  input  WIDTH  minuend; captured when start is accepted.
- inOp2  input  WIDTH  subtrahend; captured when start is accepted.
- inBi  input  1  borrow-in; captured when start is accepted.
- outBusy  output  1  high in RUN and DONE.
- outDone  output  1  one-cycle pulse; result valid.
- outRes  output  WIDTH  difference; held until the next completion.
- outBo  output  1  borrow-out; held with outRes.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, bit counter=0, borrow FF=0, shift registers=0, outBusy=0, outDone=0, outRes=0, outBo=0. Reset releases synchronously to clk (internal two-flop deassert not required; rst_n arrives pre-synchronised).
- FSM states: IDLE, RUN, DONE.
- IDLE: at edge E0 with inStart=1, the block captures inOp1/inOp2 into shift registers A/B and inBi into the borrow FF, clears the counter, and goes to RUN. inStart=0 keeps it in IDLE.
- RUN, each edge:
  - d = A[0]^B[0]^bor.
  - bnext = (~A[0]&B[0]) | (~(A[0]^B[0])&bor).
  - The result shift register shifts right with d into the MSB; A and B shift right; bor<=bnext; counter++.
  - At the edge where counter==WIDTH-1 (edge E_WIDTH), the block loads outRes with the final result register, loads outBo with bnext, and goes to DONE.
- DONE: outDone=1 for exactly one cycle (WIDTH cycles after the start edge), then returns to IDLE on the next edge.
- Total: start edge to outDone high = WIDTH cycles; a new start is accepted at the earliest on the edge after DONE.
- inStart during RUN or DONE is ignored; it is not queued.
- Operand inputs may change freely after the start edge.
- outRes/outBo change only on transition into DONE; the previous result stays visible during a new operation.
- outBusy is registered and equals (state != IDLE).
- Arithmetic is modulo 2^WIDTH. outBo=1 exactly when {inOp1} < {inOp2}+inBi (unsigned).
- Reset mid-RUN aborts immediately; outputs return to reset values; no done pulse.

Optional Feature:
- Macro SERIAL_SUB_OVERFLOW_EN.
- Defined: adds port outOvf (output, 1), signed two's-complement overflow, registered with outRes. outOvf = (A_msb != B_msb) && (res_msb != A_msb), using the captured operand MSBs. Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package serial_sub_pkg: FSM state typedef (IDLE/RUN/DONE, 2-bit), counter width constant $clog2(WIDTH), default WIDTH constant.
- One natural sub-module: fullSubtractor (combinational: a, b, bi -> d, bo). It is instantiated once and reused every cycle.

Test Plan:
- WIDTH=8: inOp1=0x35, inOp2=0x12, inBi=0, start -> outDone 8 cycles later, outRes=0x23, outBo=0, outBusy high 9 cycles.
- 0x00 - 0x01, inBi=0 -> outRes=0xFF, outBo=1.
- 0x10 - 0x0F, inBi=1 -> outRes=0x00, outBo=0.
- Start 0x55-0x11; hold inStart high and change operands to 0xFF/0xFF during RUN -> single done with 0x44; new op accepted only after DONE.
- Assert rst_n=0 at cycle 4 of RUN -> outputs and outBusy=0 asynchronously; no outDone; next op 0x09-0x03 -> 0x06.
- With SERIAL_SUB_OVERFLOW_EN: 0x80-0x01 -> outRes=0x7F, outBo=0, outOvf=1; 0x05-0x03 -> outOvf=0.
